// File: rtl/l1_mem_pkg.sv
// Shared types and sizing helpers for the L1 way array.
package l1_mem_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } init_state_e;

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned byte_cnt(input int unsigned width);
      return width / 8;
   endfunction

endpackage

// File: rtl/l1_way_bank.sv
// One cache way built from byte-wide macros so byte enables map to per-macro enables.
module l1_way_bank
   import l1_mem_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                        CLK,
   input  logic                        EN,
   input  logic                        WE,
   input  logic [byte_cnt(WIDTH)-1:0]  BE,
   input  logic [idx_w(DEPTH)-1:0]     ADDR,
   input  logic [WIDTH-1:0]            WDATA,
   output logic [WIDTH-1:0]            RDATA
);

   localparam int unsigned NB = byte_cnt(WIDTH);

   logic [NB-1:0] w_byte_en;

   // Reads enable every byte; writes only touch the enabled bytes.
   assign w_byte_en = EN ? (WE ? BE : {NB{1'b1}}) : '0;

   for (genvar b = 0; b < NB; b++) begin : g_byte
      sram_sp #(
         .WIDTH (8),
         .DEPTH (DEPTH)
      ) u_sram (
         .CLK   (CLK),
         .EN    (w_byte_en[b]),
         .WE    (WE),
         .ADDR  (ADDR),
         .WDATA (WDATA[b*8 +: 8]),
         .RDATA (RDATA[b*8 +: 8])
      );
   end

endmodule

// File: rtl/sram_sp.sv
// Behavioural single-port synchronous SRAM macro: registered read, no byte enables.
module sram_sp #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     CLK,
   input  logic                     EN,
   input  logic                     WE,
   input  logic [$clog2(DEPTH)-1:0] ADDR,
   input  logic [WIDTH-1:0]         WDATA,
   output logic [WIDTH-1:0]         RDATA
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge CLK) begin
      if (EN) begin
         if (WE) begin
            r_mem[ADDR] <= WDATA;
         end else begin
            r_rdata <= r_mem[ADDR];
         end
      end
   end

   assign RDATA = r_rdata;

endmodule

// File: rtl/l1_way_mem.sv
// Multi-way L1 storage array with an init sequencer that sweeps INIT_VAL into every entry.
module l1_way_mem
   import l1_mem_pkg::*;
#(
   parameter int unsigned     WIDTH    = 32,
   parameter int unsigned     DEPTH    = 1024,
   parameter int unsigned     WAYS     = 4,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        INIT_REQ,
   input  logic                        EN,
   input  logic [idx_w(DEPTH)-1:0]     ADDR,
   input  logic                        WE,
   input  logic [WAYS-1:0]             WAY_SEL,
   input  logic [byte_cnt(WIDTH)-1:0]  BE,
   input  logic [WIDTH-1:0]            WDATA,
   output logic [WAYS*WIDTH-1:0]       RDATA,
   output logic                        RVALID,
   output logic                        ready,
   output logic                        init_done
);

   localparam int unsigned      AW       = idx_w(DEPTH);
   localparam int unsigned      NB       = byte_cnt(WIDTH);
   localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);

   init_state_e      r_state;
   init_state_e      w_state_nxt;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    w_cnt_nxt;
   logic             r_ready;
   logic             r_rvalid;
   logic             r_init_done;
   logic             w_rvalid_nxt;
   logic             w_init_done_nxt;

   logic [WAYS-1:0]  w_way_en;
   logic             w_mem_we;
   logic [NB-1:0]    w_mem_be;
   logic [AW-1:0]    w_mem_addr;
   logic [WIDTH-1:0] w_mem_wdata;

   // State, sweep counter and status flags.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_INIT;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_rvalid    <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ready     <= (w_state_nxt == ST_READY);
         r_rvalid    <= w_rvalid_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   // Next state plus the mux between the init sweep and functional accesses.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_rvalid_nxt    = 1'b0;
      w_init_done_nxt = 1'b0;
      w_way_en        = '0;
      w_mem_we        = 1'b0;
      w_mem_be        = '0;
      w_mem_addr      = ADDR;
      w_mem_wdata     = WDATA;

      if (r_state == ST_INIT) begin
         w_way_en    = {WAYS{1'b1}};
         w_mem_we    = 1'b1;
         w_mem_be    = {NB{1'b1}};
         w_mem_addr  = r_cnt;
         w_mem_wdata = INIT_VAL;
         if (r_cnt == LAST_IDX) begin
            w_state_nxt     = ST_READY;
            w_cnt_nxt       = '0;
            w_init_done_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + AW'(1);
         end
      end else begin
         // A flush request pre-empts any access presented in the same cycle.
         if (INIT_REQ) begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
         end else if (EN) begin
            w_mem_we     = WE;
            w_mem_be     = BE;
            w_way_en     = WE ? WAY_SEL : {WAYS{1'b1}};
            w_rvalid_nxt = !WE;
         end
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      l1_way_bank #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_bank (
         .CLK   (CLK),
         .EN    (w_way_en[w]),
         .WE    (w_mem_we),
         .BE    (w_mem_be),
         .ADDR  (w_mem_addr),
         .WDATA (w_mem_wdata),
         .RDATA (RDATA[w*WIDTH +: WIDTH])
      );
   end

   assign ready     = r_ready;
   assign RVALID    = r_rvalid;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_l1_way_mem.sv
// Self-checking bench for l1_way_mem: directed table, corner sequences and a random run against a model.
module tb_l1_way_mem;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned WAYS  = 4;
   localparam logic [31:0] IV    = 32'hA5A5_A5A5;

   logic         CLK;
   logic         RST_N;
   logic         INIT_REQ;
   logic         EN;
   logic         WE;
   logic [3:0]   ADDR;
   logic [3:0]   WAY_SEL;
   logic [3:0]   BE;
   logic [31:0]  WDATA;
   logic [127:0] RDATA;
   logic         RVALID;
   logic         ready;
   logic         init_done;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: array contents, readiness and remaining sweep cycles.
   logic [31:0]  m_mem [WAYS][DEPTH];
   logic         m_ready;
   int           m_left;
   logic [127:0] m_rdata;
   logic         m_rd_known;

   typedef struct {
      logic         en;
      logic         we;
      logic [3:0]   addr;
      logic [3:0]   ws;
      logic [3:0]   be;
      logic [31:0]  wd;
      logic         exp_rv;
      logic         chk_rd;
      logic [127:0] exp_rd;
   } vec_t;

   vec_t tbl [11];

   l1_way_mem #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .WAYS     (WAYS),
      .INIT_VAL (IV)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .INIT_REQ  (INIT_REQ),
      .EN        (EN),
      .ADDR      (ADDR),
      .WE        (WE),
      .WAY_SEL   (WAY_SEL),
      .BE        (BE),
      .WDATA     (WDATA),
      .RDATA     (RDATA),
      .RVALID    (RVALID),
      .ready     (ready),
      .init_done (init_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      m_ready    = 1'b0;
      m_left     = DEPTH;
      m_rd_known = 1'b0;
      for (int w = 0; w < WAYS; w++)
         for (int a = 0; a < DEPTH; a++) m_mem[w][a] = IV;
   endtask

   // Drive one cycle of inputs, advance the model, clock, then compare.
   task automatic cycle(input logic en, input logic we, input logic [3:0] addr,
                        input logic [3:0] ws, input logic [3:0] be,
                        input logic [31:0] wd, input logic ireq);
      logic exp_rv;
      logic exp_done;
      exp_rv   = 1'b0;
      exp_done = 1'b0;
      EN = en; WE = we; ADDR = addr; WAY_SEL = ws; BE = be; WDATA = wd; INIT_REQ = ireq;
      if (!m_ready) begin
         m_left--;
         if (m_left == 0) begin
            m_ready  = 1'b1;
            exp_done = 1'b1;
         end
      end else if (ireq) begin
         m_ready = 1'b0;
         m_left  = DEPTH;
         for (int w = 0; w < WAYS; w++)
            for (int a = 0; a < DEPTH; a++) m_mem[w][a] = IV;
      end else if (en && !we) begin
         exp_rv = 1'b1;
         for (int w = 0; w < WAYS; w++) m_rdata[w*32 +: 32] = m_mem[w][addr];
         m_rd_known = 1'b1;
      end else if (en && we) begin
         for (int w = 0; w < WAYS; w++)
            for (int b = 0; b < 4; b++)
               if (ws[w] && be[b]) m_mem[w][addr][b*8 +: 8] = wd[b*8 +: 8];
      end
      @(posedge CLK);
      #1;
      check("ready", 128'(ready), 128'(m_ready));
      check("rvalid", 128'(RVALID), 128'(exp_rv));
      check("init_done", 128'(init_done), 128'(exp_done));
      if (m_rd_known) check("rdata", RDATA, m_rdata);
   endtask

   // Idle through a sweep and confirm its length; optional stray access and held flush request.
   task automatic sweep_expect(input int inject_at, input logic ireq_hold);
      int n;
      n = 0;
      do begin
         if (n + 1 == inject_at) cycle(1'b1, 1'b1, 4'd0, 4'hF, 4'hF, 32'h0, ireq_hold);
         else                    cycle(1'b0, 1'b0, 4'd0, 4'h0, 4'h0, 32'h0, ireq_hold);
         n++;
      end while (!ready && n < 40);
      check("sweep_len", 128'(n), 128'(DEPTH));
   endtask

   task automatic async_reset_check();
      #2;
      RST_N = 1'b0;
      #1;
      check("async_ready", 128'(ready), 128'(0));
      check("async_rvalid", 128'(RVALID), 128'(0));
      check("async_init_done", 128'(init_done), 128'(0));
      #1;
      RST_N = 1'b1;
      model_reset();
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, 4'(a), 4'h0, 4'h0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 4'd0, 4'h0, 4'h0, 32'h0, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 4'd3, 4'b0100, 4'b0011, 32'h1234_5678, 1'b0, 1'b0, 128'h0};
      tbl[1]  = '{1'b1, 1'b0, 4'd3, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, {IV, 32'hA5A5_5678, IV, IV}};
      tbl[2]  = '{1'b0, 1'b0, 4'd3, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, {IV, 32'hA5A5_5678, IV, IV}};
      tbl[3]  = '{1'b1, 1'b1, 4'd7, 4'hF, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, {IV, 32'hA5A5_5678, IV, IV}};
      tbl[4]  = '{1'b1, 1'b0, 4'd7, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, {4{32'hDEAD_BEEF}}};
      tbl[5]  = '{1'b1, 1'b1, 4'd7, 4'h0, 4'hF, 32'h0, 1'b0, 1'b1, {4{32'hDEAD_BEEF}}};
      tbl[6]  = '{1'b1, 1'b1, 4'd7, 4'hF, 4'h0, 32'h0, 1'b0, 1'b1, {4{32'hDEAD_BEEF}}};
      tbl[7]  = '{1'b1, 1'b0, 4'd7, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, {4{32'hDEAD_BEEF}}};
      tbl[8]  = '{1'b1, 1'b0, 4'd0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, {4{IV}}};
      tbl[9]  = '{1'b1, 1'b1, 4'd5, 4'b0001, 4'b1000, 32'h1122_3344, 1'b0, 1'b0, 128'h0};
      tbl[10] = '{1'b1, 1'b0, 4'd5, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, {IV, IV, IV, 32'h11A5_A5A5}};

      RST_N = 1'b0; INIT_REQ = 1'b0; EN = 1'b0; WE = 1'b0;
      ADDR = '0; WAY_SEL = '0; BE = '0; WDATA = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check("rst_ready", 128'(ready), 128'(0));
      check("rst_rvalid", 128'(RVALID), 128'(0));
      check("rst_init_done", 128'(init_done), 128'(0));
      RST_N = 1'b1;

      // Power-on sweep with a stray write presented in its fifth cycle.
      sweep_expect(5, 1'b0);
      read_all();

      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].ws, tbl[i].be, tbl[i].wd, 1'b0);
         check($sformatf("tbl%0d_rvalid", i), 128'(RVALID), 128'(tbl[i].exp_rv));
         if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), RDATA, tbl[i].exp_rd);
      end

      // Flush request colliding with a write; request kept high during the sweep.
      cycle(1'b1, 1'b1, 4'd3, 4'hF, 4'hF, 32'h0, 1'b1);
      check("flush_ready_drop", 128'(ready), 128'(0));
      sweep_expect(0, 1'b1);
      read_all();

      // Async reset while RVALID is high, then while init_done is high, then mid-sweep.
      cycle(1'b1, 1'b0, 4'd2, 4'h0, 4'h0, 32'h0, 1'b0);
      async_reset_check();
      sweep_expect(0, 1'b0);
      async_reset_check();
      repeat (9) cycle(1'b0, 1'b0, 4'd0, 4'h0, 4'h0, 32'h0, 1'b0);
      async_reset_check();
      sweep_expect(0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom), 4'($urandom), $urandom, $urandom_range(0, 49) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
